// File: rtl/coproc_pkg.sv
// ---------------------------------------------------------------------------
// coproc_pkg
// Shared definitions for the matrix coprocessor command front-end:
//   - STATE_W    : width of the exported FSM state encoding
//   - state_t    : FSM states IDLE(0), ISSUE(1), WAIT(2), DONE(3), ERR(4)
//   - DEF_OP_W   : default opcode width
//   - DEF_SIZE_W : default matrix-size field width
// ---------------------------------------------------------------------------
package coproc_pkg;

    localparam int STATE_W    = 3;
    localparam int DEF_OP_W   = 3;
    localparam int DEF_SIZE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

endpackage

// File: rtl/cmd_fifo.sv
// ---------------------------------------------------------------------------
// cmd_fifo
// Parametrised synchronous FIFO holding packed host commands.
// Ports:
//   clk, rst      : rising-edge clock, asynchronous active-high reset
//   push, din     : write request and data (ignored while full)
//   pop, dout     : read request (ignored while empty); dout shows the head
//   full, empty   : occupancy flags
//   count         : number of stored entries (0..DEPTH)
// ---------------------------------------------------------------------------
module cmd_fifo #(
    parameter  int WIDTH = 6,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem[rd_ptr];

    // A full FIFO never accepts a write, even if a read happens in the
    // same cycle; this keeps the accept decision independent of the FSM.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage and pointers; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/coproc_cmd_interface.sv
// ---------------------------------------------------------------------------
// coproc_cmd_interface
// Command front-end of the matrix coprocessor. Buffers host commands in a
// FIFO, issues them one at a time to the control unit over a start/done
// handshake, supervises each command with a timeout and reports status.
// Ports:
//   clk, rst                    : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready         : host command handshake
//   cmd_op, cmd_size            : host opcode and matrix size
//   cu_start                    : one-cycle start pulse to the control unit
//   cu_op, cu_size              : command presented to the control unit
//   cu_done, cu_overflow        : completion and overflow from control unit
//   clr_status                  : clears sticky overflow / timeout flags
//   ready                       : idle with an empty FIFO
//   done_pulse                  : one-cycle pulse per completed command
//   overflow, timeout_err       : sticky status flags
//   state                       : FSM encoding
//   op_code_o                   : opcode in execution, or last executed
//   fifo_count                  : FIFO occupancy
// ---------------------------------------------------------------------------
module coproc_cmd_interface
    import coproc_pkg::*;
#(
    parameter  int OP_W    = DEF_OP_W,
    parameter  int SIZE_W  = DEF_SIZE_W,
    parameter  int DEPTH   = 4,
    parameter  int TIMEOUT = 1024,
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [OP_W-1:0]    cmd_op,
    input  logic [SIZE_W-1:0]  cmd_size,
    output logic               cu_start,
    output logic [OP_W-1:0]    cu_op,
    output logic [SIZE_W-1:0]  cu_size,
    input  logic               cu_done,
    input  logic               cu_overflow,
    input  logic               clr_status,
    output logic               ready,
    output logic               done_pulse,
    output logic               overflow,
    output logic               timeout_err,
    output logic [STATE_W-1:0] state,
    output logic [OP_W-1:0]    op_code_o,
    output logic [CNT_W-1:0]   fifo_count
);

    localparam int DATA_W = OP_W + SIZE_W;
    localparam int TMR_W  = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_t             state_q;
    state_t             state_d;
    logic [TMR_W-1:0]   timer_q;
    logic               timer_expired;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic [DATA_W-1:0]  fifo_dout;
    logic               ovf_set;
    logic               tmo_set;

    assign push          = cmd_valid && !fifo_full;
    assign pop           = (state_q == IDLE) && !fifo_empty;
    assign cmd_ready     = !fifo_full;
    assign timer_expired = (timer_q == TMR_LAST);

    assign cu_start   = (state_q == ISSUE);
    assign done_pulse = (state_q == DONE);
    assign ready      = (state_q == IDLE) && fifo_empty;
    assign state      = state_q;
    assign op_code_o  = cu_op;

    // Completion takes priority over expiry when both land in the same cycle.
    assign ovf_set = (state_q == WAIT) && cu_done && cu_overflow;
    assign tmo_set = (state_q == WAIT) && !cu_done && timer_expired;

    cmd_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({cmd_op, cmd_size}),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Next-state logic. cu_done outside WAIT is ignored; ERR holds until the
    // host acknowledges the timeout with clr_status.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT: begin
                if (cu_done) begin
                    state_d = DONE;
                end else if (timer_expired) begin
                    state_d = ERR;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     if (clr_status) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Timer is cleared while the start pulse is out and counts WAIT cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
        end else if (state_q == ISSUE) begin
            timer_q <= '0;
        end else if (state_q == WAIT) begin
            timer_q <= timer_q + 1'b1;
        end
    end

    // Command registers load on pop and hold until the next pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cu_op   <= '0;
            cu_size <= '0;
        end else if (pop) begin
            cu_op   <= fifo_dout[DATA_W-1 -: OP_W];
            cu_size <= fifo_dout[SIZE_W-1:0];
        end
    end

    // Sticky flags: a set in the same cycle as clr_status wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clr_status) begin
                overflow <= 1'b0;
            end
            if (tmo_set) begin
                timeout_err <= 1'b1;
            end else if (clr_status) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_coproc_cmd_interface.sv
// ---------------------------------------------------------------------------
// tb_coproc_cmd_interface
// Directed bench for coproc_cmd_interface with DEPTH=4, TIMEOUT=8.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_coproc_cmd_interface;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = '0;
    logic [2:0] cmd_size = '0;
    logic       cu_start;
    logic [2:0] cu_op;
    logic [2:0] cu_size;
    logic       cu_done = 1'b0;
    logic       cu_overflow = 1'b0;
    logic       clr_status = 1'b0;
    logic       ready;
    logic       done_pulse;
    logic       overflow;
    logic       timeout_err;
    logic [2:0] state;
    logic [2:0] op_code_o;
    logic [2:0] fifo_count;

    int checks = 0;
    int errors = 0;
    logic seen_start;

    always #5 clk = ~clk;

    coproc_cmd_interface #(
        .OP_W    (3),
        .SIZE_W  (3),
        .DEPTH   (4),
        .TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_size    (cmd_size),
        .cu_start    (cu_start),
        .cu_op       (cu_op),
        .cu_size     (cu_size),
        .cu_done     (cu_done),
        .cu_overflow (cu_overflow),
        .clr_status  (clr_status),
        .ready       (ready),
        .done_pulse  (done_pulse),
        .overflow    (overflow),
        .timeout_err (timeout_err),
        .state       (state),
        .op_code_o   (op_code_o),
        .fifo_count  (fifo_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [2:0] op, input logic [2:0] size);
        cmd_valid = valid;
        cmd_op    = op;
        cmd_size  = size;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Waits (bounded) for the start pulse, checks the issued command, then
    // completes it after one WAIT cycle and checks the done pulse.
    task automatic serveCmd(input string tag, input logic [2:0] exp_op, input logic [2:0] exp_size,
                            input logic ovf, input logic clr);
        for (int i = 0; i < 20 && !cu_start; i++) tick();
        checkOutput({tag, "_start"}, 32'(cu_start), 32'd1);
        checkOutput({tag, "_op"}, 32'(cu_op), 32'(exp_op));
        checkOutput({tag, "_size"}, 32'(cu_size), 32'(exp_size));
        tick();
        cu_done     = 1'b1;
        cu_overflow = ovf;
        clr_status  = clr;
        tick();
        cu_done     = 1'b0;
        cu_overflow = 1'b0;
        clr_status  = 1'b0;
        checkOutput({tag, "_done"}, 32'(done_pulse), 32'd1);
        tick();
        checkOutput({tag, "_done_clr"}, 32'(done_pulse), 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset values
        tick();
        tick();
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_start", 32'(cu_start), 32'd0);
        checkOutput("rst_count", 32'(fifo_count), 32'd0);
        checkOutput("rst_ovf", 32'(overflow), 32'd0);
        checkOutput("rst_tmo", 32'(timeout_err), 32'd0);
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("rst_ready", 32'(ready), 32'd1);
        rst = 1'b0;

        // 1: single command, done after 5 WAIT cycles
        applyStimulus(1'b1, 3'b010, 3'd4);
        tick();
        applyStimulus(1'b0, 3'd0, 3'd0);
        checkOutput("t1_count1", 32'(fifo_count), 32'd1);
        checkOutput("t1_notready", 32'(ready), 32'd0);
        tick();
        checkOutput("t1_start", 32'(cu_start), 32'd1);
        checkOutput("t1_op", 32'(cu_op), 32'd2);
        checkOutput("t1_size", 32'(cu_size), 32'd4);
        checkOutput("t1_state_issue", 32'(state), 32'd1);
        checkOutput("t1_opcode_o", 32'(op_code_o), 32'd2);
        tick();
        checkOutput("t1_start_one", 32'(cu_start), 32'd0);
        repeat (4) tick();
        checkOutput("t1_state_wait", 32'(state), 32'd2);
        cu_done = 1'b1;
        tick();
        cu_done = 1'b0;
        checkOutput("t1_done", 32'(done_pulse), 32'd1);
        checkOutput("t1_state_done", 32'(state), 32'd3);
        checkOutput("t1_ovf", 32'(overflow), 32'd0);
        tick();
        checkOutput("t1_ready", 32'(ready), 32'd1);

        // 2: back-to-back pushes with the control unit stalled
        applyStimulus(1'b1, 3'd1, 3'd1);
        tick();
        checkOutput("t2_c1", 32'(fifo_count), 32'd1);
        applyStimulus(1'b1, 3'd2, 3'd2);
        tick();
        checkOutput("t2_c2", 32'(fifo_count), 32'd1);
        checkOutput("t2_first_op", 32'(cu_op), 32'd1);
        checkOutput("t2_first_start", 32'(cu_start), 32'd1);
        applyStimulus(1'b1, 3'd3, 3'd3);
        tick();
        checkOutput("t2_c3", 32'(fifo_count), 32'd2);
        applyStimulus(1'b1, 3'd4, 3'd4);
        tick();
        checkOutput("t2_c4", 32'(fifo_count), 32'd3);
        checkOutput("t2_rdy3", 32'(cmd_ready), 32'd1);
        applyStimulus(1'b1, 3'd5, 3'd5);
        tick();
        checkOutput("t2_c5", 32'(fifo_count), 32'd4);
        checkOutput("t2_full_rdy", 32'(cmd_ready), 32'd0);
        applyStimulus(1'b1, 3'd6, 3'd6);
        tick();
        checkOutput("t2_c6_drop", 32'(fifo_count), 32'd4);
        applyStimulus(1'b0, 3'd0, 3'd0);
        cu_done = 1'b1;
        tick();
        cu_done = 1'b0;
        checkOutput("t2_c1_done", 32'(done_pulse), 32'd1);

        // 3: sticky overflow across commands, clear, and set-beats-clear
        serveCmd("t2_cmd2", 3'd2, 3'd2, 1'b1, 1'b0);
        checkOutput("t3_ovf_set", 32'(overflow), 32'd1);
        serveCmd("t2_cmd3", 3'd3, 3'd3, 1'b0, 1'b0);
        checkOutput("t3_ovf_sticky", 32'(overflow), 32'd1);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        checkOutput("t3_ovf_clr", 32'(overflow), 32'd0);
        serveCmd("t2_cmd4", 3'd4, 3'd4, 1'b1, 1'b1);
        checkOutput("t3_set_wins", 32'(overflow), 32'd1);
        serveCmd("t2_cmd5", 3'd5, 3'd5, 1'b0, 1'b0);
        checkOutput("t2_drained", 32'(ready), 32'd1);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        checkOutput("t3_ovf_clr2", 32'(overflow), 32'd0);

        // 4: timeout with one command queued behind
        applyStimulus(1'b1, 3'd6, 3'd1);
        tick();
        applyStimulus(1'b1, 3'd7, 3'd2);
        tick();
        applyStimulus(1'b0, 3'd0, 3'd0);
        checkOutput("t4_op", 32'(cu_op), 32'd6);
        tick();
        repeat (7) tick();
        checkOutput("t4_wait8", 32'(state), 32'd2);
        checkOutput("t4_tmo_pre", 32'(timeout_err), 32'd0);
        tick();
        checkOutput("t4_err", 32'(state), 32'd4);
        checkOutput("t4_tmo", 32'(timeout_err), 32'd1);
        checkOutput("t4_queued", 32'(fifo_count), 32'd1);
        cu_done = 1'b1;
        tick();
        cu_done = 1'b0;
        seen_start = 1'b0;
        repeat (3) begin
            tick();
            seen_start |= cu_start;
        end
        checkOutput("t4_err_hold", 32'(state), 32'd4);
        checkOutput("t4_no_issue", 32'(seen_start), 32'd0);
        checkOutput("t4_no_done", 32'(done_pulse), 32'd0);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        checkOutput("t4_idle", 32'(state), 32'd0);
        checkOutput("t4_tmo_clr", 32'(timeout_err), 32'd0);
        serveCmd("t4_cmd7", 3'd7, 3'd2, 1'b0, 1'b0);

        // 5: cu_done on the same cycle the timer reaches its limit
        applyStimulus(1'b1, 3'd5, 3'd3);
        tick();
        applyStimulus(1'b0, 3'd0, 3'd0);
        tick();
        tick();
        repeat (7) tick();
        checkOutput("t5_wait", 32'(state), 32'd2);
        cu_done     = 1'b1;
        cu_overflow = 1'b1;
        tick();
        cu_done     = 1'b0;
        cu_overflow = 1'b0;
        checkOutput("t5_done_state", 32'(state), 32'd3);
        checkOutput("t5_no_tmo", 32'(timeout_err), 32'd0);
        checkOutput("t5_ovf", 32'(overflow), 32'd1);
        tick();

        // 6: reset mid-WAIT with two commands queued
        applyStimulus(1'b1, 3'd1, 3'd1);
        tick();
        applyStimulus(1'b1, 3'd2, 3'd2);
        tick();
        applyStimulus(1'b1, 3'd3, 3'd3);
        tick();
        applyStimulus(1'b0, 3'd0, 3'd0);
        tick();
        checkOutput("t6_pre_state", 32'(state), 32'd2);
        checkOutput("t6_pre_count", 32'(fifo_count), 32'd2);
        #2 rst = 1'b1;
        #1;
        checkOutput("t6_state", 32'(state), 32'd0);
        checkOutput("t6_count", 32'(fifo_count), 32'd0);
        checkOutput("t6_ovf", 32'(overflow), 32'd0);
        checkOutput("t6_op", 32'(cu_op), 32'd0);
        checkOutput("t6_opcode_o", 32'(op_code_o), 32'd0);
        checkOutput("t6_cmd_ready", 32'(cmd_ready), 32'd1);
        tick();
        rst = 1'b0;
        seen_start = 1'b0;
        repeat (5) begin
            tick();
            seen_start |= cu_start;
        end
        checkOutput("t6_no_reissue", 32'(seen_start), 32'd0);
        checkOutput("t6_ready", 32'(ready), 32'd1);
        applyStimulus(1'b1, 3'd4, 3'd5);
        tick();
        applyStimulus(1'b0, 3'd0, 3'd0);
        tick();
        checkOutput("t6_new_start", 32'(cu_start), 32'd1);
        checkOutput("t6_new_op", 32'(cu_op), 32'd4);
        checkOutput("t6_new_size", 32'(cu_size), 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
